multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Multicycle signed 32-bit multiply/divide unit for the execute stage.
//  Iterates over one shared 32-bit add/subtract and invert+1 negation datapath
//  under an FSM: 32-step shift-add multiply, 32-step restoring divide.
//  Pipeline stalls while busy=1. Writeback takes data_result when data_resultRDY pulses.
// PARAMETERS
//  WIDTH   32  operand/result width (only 32 supported)
//  CNT_W   5   iteration counter width, log2(WIDTH)
// PORTS
//  clock           in   1      single clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  ctrl_MULT       in   1      1-cycle start pulse, signed multiply A*B
//  ctrl_DIV        in   1      1-cycle start pulse, signed divide A/B
//  data_operandA   in   32     operand A, sampled on the start edge only
//  data_operandB   in   32     operand B, sampled on the start edge only
//  data_result     out  32     low product word or quotient; held until next start
//  data_exception  out  1      valid while data_resultRDY=1
//  data_resultRDY  out  1      1-cycle completion pulse
//  busy            out  1      high from the start edge until the RDY cycle ends
// BEHAVIOUR
//  - Reset (async, reset_n=0):
//    - state=IDLE; all outputs 0; counter and operand registers 0.
//  - States and transitions:
//    - IDLE: start seen -> PREP.
//    - PREP: latch |A| and |B|, record sign = A[31]^B[31]; -> RUN, cnt=0.
//    - RUN: one iteration per cycle, cnt 0..31; at cnt=31 -> FIX.
//    - FIX: negate magnitude if sign=1; evaluate exception; -> DONE.
//    - DONE: data_resultRDY=1 for exactly one cycle; -> IDLE.
//  - Latency: start sampled on edge E; RDY rises on E+34 and falls on E+35.
//    busy rises on E and falls on E+35.
//  - Both ctrl_MULT and ctrl_DIV high in IDLE: multiply wins.
//  - Start pulses while busy=1 are ignored; no queuing.
//  - Multiply:
//    - 64-bit magnitude product; result = low 32 bits of the signed product.
//    - exception=1 when the signed product does not fit in 32 bits.
//  - Divide:
//    - Quotient truncates toward zero; remainder is discarded.
//    - B=0: result=0, exception=1, full latency.
//    - A=0x80000000, B=-1: result=0x80000000, exception=1.
//  - Magnitude 0x80000000 is handled as unsigned 2^31, so there is no internal overflow.
//  - reset_n low mid-operation aborts at once. No RDY is produced for the aborted op.
// CONFIGURATION
//  - MULTDIV_FAST_ZERO_EN defined:
//    - IDLE goes straight to DONE when the multiply has A=0 or B=0, or the divide has B=0.
//    - RDY rises on E+1; result and exception values are as above.
//  - MULTDIV_FAST_ZERO_EN undefined: every operation takes the full E+34 latency.
// STRUCTURE
//  - Package multdiv_pkg:
//    - state enum {IDLE, PREP, RUN, FIX, DONE};
//    - WIDTH and CNT_W constants;
//    - INT_MIN constant 32'h8000_0000.
//  - Sub-module negate32 (in[31:0] -> out[31:0] = ~in + 1), built on the ALU inverter.
//    Instantiated twice: PREP absolute values and FIX sign application.
//  - Everything else (FIX exception compare, 64-bit shift register, restoring-divide
//    subtract) sits inline in this module.
// TESTING
//  - MULT A=7, B=-6 at edge E -> RDY at E+34, result=0xFFFFFFD6, exc=0, busy low at E+35.
//  - MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exc=1.
//  - DIV A=-100, B=7 -> result=0xFFFFFFF2 (-14), exc=0.
//  - DIV A=5, B=0 -> result=0, exc=1.
//    RDY at E+34, or at E+1 with MULTDIV_FAST_ZERO_EN.
//  - DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exc=1.
//  - Mid-op events:
//    - ctrl_DIV at E+10 during a MULT is ignored; one RDY at E+34 carries the MULT result.
//    - reset_n=0 at E+20 -> outputs 0 at once; no RDY follows.

Source files
------------

// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared types and constants for the multicycle signed multiply/divide unit.
//   state_t  : sequencer states IDLE -> PREP -> RUN -> FIX -> DONE
//   op_t     : operation latched at the start edge
//   WIDTH    : operand/result width (only 32 supported)
//   CNT_W    : iteration counter width, log2(WIDTH)
//   INT_MIN  : most negative 32-bit value
//   mul_ovf  : does a sign-applied 64-bit magnitude product overflow 32 bits
// -----------------------------------------------------------------------------
package multdiv_pkg;

   localparam int          WIDTH   = 32;
   localparam int          CNT_W   = 5;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      RUN  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   typedef enum logic {
      OP_MUL = 1'b0,
      OP_DIV = 1'b1
   } op_t;

   // A magnitude product fits a signed 32-bit result when its upper word is
   // zero and the lower word is at most 2^31-1 (positive) or 2^31 (negative).
   function automatic logic mul_ovf(input logic [31:0] hi,
                                    input logic [31:0] lo,
                                    input logic        neg);
      logic ovf;
      if (hi != 32'h0000_0000) begin
         ovf = 1'b1;
      end else if (neg == 1'b0) begin
         ovf = lo[31];
      end else begin
         ovf = lo[31] & (lo != INT_MIN);
      end
      return ovf;
   endfunction

endpackage

// File: rtl/multdiv_sequencer_negate32.sv
// -----------------------------------------------------------------------------
// negate32
// Two's complement negation on the ALU inverter: dout = ~din + 1.
//   din   in  32  value to negate
//   dout  out 32  negated value (0x80000000 maps onto itself)
// -----------------------------------------------------------------------------
module negate32 (
   input  logic [31:0] din,
   output logic [31:0] dout
);

   assign dout = ~din + 32'd1;

endmodule

// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
// Multicycle signed 32-bit multiply/divide unit for the execute stage. One
// shared 33-bit add/subtract datapath is stepped 32 times: shift-add for
// multiply, restoring subtract for divide. Operands become magnitudes in PREP,
// the sign is re-applied and the exception evaluated in FIX.
//
// Ports
//   clock           in   1   rising-edge clock
//   reset_n         in   1   asynchronous active-low reset (aborts any op)
//   ctrl_MULT       in   1   start pulse, signed A*B (wins over ctrl_DIV)
//   ctrl_DIV        in   1   start pulse, signed A/B (truncating)
//   data_operandA   in   32  operand A, sampled on the start edge only
//   data_operandB   in   32  operand B, sampled on the start edge only
//   data_result     out  32  low product word or quotient
//   data_exception  out  1   overflow / divide-by-zero, valid with RDY
//   data_resultRDY  out  1   one-cycle completion pulse
//   busy            out  1   high from the start edge until the RDY cycle ends
//
// Latency: start on edge E, RDY rises on E+34 and falls with busy on E+35.
//
// Build option: MULTDIV_FAST_ZERO_EN -- multiply with a zero operand or divide
// by zero skips the iteration and raises RDY on E+1.
// -----------------------------------------------------------------------------
module multdiv_sequencer
   import multdiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   state_t             state_r;
   state_t             state_s;
   op_t                op_r;
   logic               sign_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [31:0]        hi_r;       // upper product word / partial remainder
   logic [31:0]        lo_r;       // operand A, then lower product word / quotient
   logic [31:0]        b_r;        // operand B, then |B|
   logic [31:0]        result_r;
   logic               exc_r;
   logic               rdy_r;
   logic               busy_r;

   logic               start_s;
   logic               fast_s;
   logic               fast_exc_s;
   logic [31:0]        neg_a_s;
   logic [31:0]        neg2_in_s;
   logic [31:0]        neg2_s;
   logic [31:0]        abs_a_s;
   logic [31:0]        abs_b_s;
   logic [31:0]        fix_val_s;
   logic [31:0]        add_a_s;
   logic [31:0]        add_b_s;
   logic               cin_s;
   logic [32:0]        sum_s;
   logic [31:0]        hi_next_s;
   logic [31:0]        lo_next_s;
   logic [31:0]        fix_res_s;
   logic               fix_exc_s;

   assign start_s    = ctrl_MULT | ctrl_DIV;
   assign fast_exc_s = ~ctrl_MULT;

`ifdef MULTDIV_FAST_ZERO_EN
   assign fast_s = ctrl_MULT ? ((data_operandA == 32'h0000_0000) ||
                                (data_operandB == 32'h0000_0000))
                             : (ctrl_DIV && (data_operandB == 32'h0000_0000));
`else
   assign fast_s = 1'b0;
`endif

   // First negator: |A| in PREP (lo_r still holds raw A there).
   negate32 u_neg_prep (
      .din  (lo_r),
      .dout (neg_a_s)
   );

   // Second negator is shared: |B| in PREP, sign application in FIX.
   assign neg2_in_s = (state_r == FIX) ? lo_r : b_r;

   negate32 u_neg_fix (
      .din  (neg2_in_s),
      .dout (neg2_s)
   );

   assign abs_a_s   = lo_r[31] ? neg_a_s : lo_r;
   assign abs_b_s   = b_r[31]  ? neg2_s  : b_r;
   assign fix_val_s = sign_r   ? neg2_s  : lo_r;

   // Shared adder operand selection: add |B| for multiply, subtract |B| for divide.
   always_comb begin
      add_a_s = hi_r;
      add_b_s = 32'h0000_0000;
      cin_s   = 1'b0;
      if (op_r == OP_DIV) begin
         add_a_s = {hi_r[30:0], lo_r[31]};
         add_b_s = ~b_r;
         cin_s   = 1'b1;
      end else begin
         add_a_s = hi_r;
         add_b_s = lo_r[0] ? b_r : 32'h0000_0000;
         cin_s   = 1'b0;
      end
   end

   assign sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {32'h0000_0000, cin_s};

   // One iteration: multiply shifts {carry,sum,lo} right; divide keeps the
   // trial difference when it did not borrow and shifts the quotient bit in.
   always_comb begin
      hi_next_s = hi_r;
      lo_next_s = lo_r;
      if (op_r == OP_DIV) begin
         hi_next_s = sum_s[32] ? sum_s[31:0] : add_a_s;
         lo_next_s = {lo_r[30:0], sum_s[32]};
      end else begin
         hi_next_s = sum_s[32:1];
         lo_next_s = {sum_s[0], lo_r[31:1]};
      end
   end

   // Final result and exception from the magnitude registers and recorded sign.
   always_comb begin
      fix_res_s = fix_val_s;
      fix_exc_s = 1'b0;
      if (op_r == OP_DIV) begin
         if (b_r == 32'h0000_0000) begin
            fix_res_s = 32'h0000_0000;
            fix_exc_s = 1'b1;
         end else begin
            // Only INT_MIN / -1 yields a positive 2^31 quotient.
            fix_res_s = fix_val_s;
            fix_exc_s = ~sign_r & lo_r[31];
         end
      end else begin
         fix_res_s = fix_val_s;
         fix_exc_s = mul_ovf(hi_r, lo_r, sign_r);
      end
   end

   // Sequencer state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; DONE lasts until its single RDY cycle has been issued.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               state_s = fast_s ? DONE : PREP;
            end else begin
               state_s = IDLE;
            end
         end
         PREP: state_s = RUN;
         RUN: begin
            if (cnt_r == {CNT_W{1'b1}}) begin
               state_s = FIX;
            end else begin
               state_s = RUN;
            end
         end
         FIX:  state_s = DONE;
         DONE: begin
            if (rdy_r) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Datapath and registered outputs, advanced according to the current state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_r     <= OP_MUL;
         sign_r   <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
         hi_r     <= 32'h0000_0000;
         lo_r     <= 32'h0000_0000;
         b_r      <= 32'h0000_0000;
         result_r <= 32'h0000_0000;
         exc_r    <= 1'b0;
         rdy_r    <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  op_r   <= ctrl_MULT ? OP_MUL : OP_DIV;
                  sign_r <= data_operandA[31] ^ data_operandB[31];
                  lo_r   <= data_operandA;
                  b_r    <= data_operandB;
                  hi_r   <= 32'h0000_0000;
                  cnt_r  <= {CNT_W{1'b0}};
                  busy_r <= 1'b1;
                  if (fast_s) begin
                     result_r <= 32'h0000_0000;
                     exc_r    <= fast_exc_s;
                  end
               end
            end
            PREP: begin
               lo_r  <= abs_a_s;
               b_r   <= abs_b_s;
               hi_r  <= 32'h0000_0000;
               cnt_r <= {CNT_W{1'b0}};
            end
            RUN: begin
               hi_r  <= hi_next_s;
               lo_r  <= lo_next_s;
               cnt_r <= cnt_r + 5'd1;
            end
            FIX: begin
               result_r <= fix_res_s;
               exc_r    <= fix_exc_s;
               rdy_r    <= 1'b1;
            end
            DONE: begin
               if (rdy_r) begin
                  rdy_r  <= 1'b0;
                  busy_r <= 1'b0;
                  exc_r  <= 1'b0;
               end else begin
                  // Early-completion path enters DONE without RDY raised yet.
                  rdy_r  <= 1'b1;
               end
            end
            default: begin
               rdy_r  <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign data_result    = result_r;
   assign data_exception = exc_r;
   assign data_resultRDY = rdy_r;
   assign busy           = busy_r;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multdiv_sequencer
// Self-checking bench for multdiv_sequencer: a directed vector table, random
// operations against an arithmetic reference model, and hand-written
// sequences for a start pulse while busy and a reset in the middle of an op.
// -----------------------------------------------------------------------------
module tb_multdiv_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   multdiv_sequencer dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   typedef struct {
      bit          m;
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic        exp_exc;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: exact signed arithmetic in 64 bits, then range test.
   function automatic void ref_op(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
      longint sa;
      longint sb;
      longint p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (m) begin
         p   = sa * sb;
         res = p[31:0];
         exc = (p > 64'sh7FFF_FFFF) || (p < -64'sh8000_0000);
      end else if (b == 32'h0) begin
         res = 32'h0;
         exc = 1'b1;
      end else begin
         p   = sa / sb;
         res = p[31:0];
         exc = (p > 64'sh7FFF_FFFF);
      end
   endfunction

   function automatic int exp_lat(input bit m, input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_FAST_ZERO_EN
      if ((m && (a == 32'h0 || b == 32'h0)) || (!m && b == 32'h0)) return 1;
`endif
      return 34;
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h0000_0000;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = 32'($signed($urandom_range(0, 200)) - 200'sd100);
         4: v = $urandom >> $urandom_range(8, 31);
         5: v = $signed($urandom) >>> $urandom_range(8, 31);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Issue one op and compare latency, busy, result and exception.
   task automatic run_op(input string tag, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ee);
      bit          seen;
      int          lat;
      int          elat;
      logic [31:0] r;
      logic        x;
      elat = exp_lat(m, a, b);
      @(negedge clock);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      check({tag, " busy_at_E"}, {31'd0, busy}, 32'd1);
      seen = 1'b0;
      lat  = 0;
      r    = 32'h0;
      x    = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clock);
         #1;
         if (!seen && data_resultRDY) begin
            seen = 1'b1;
            lat  = k;
            r    = data_result;
            x    = data_exception;
            check({tag, " busy_at_rdy"}, {31'd0, busy}, 32'd1);
         end else if (seen) begin
            check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
            check({tag, " rdy_after"}, {31'd0, data_resultRDY}, 32'd0);
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: no RDY within 60 cycles, expected at %0d", tag, elat);
      end else begin
         check({tag, " latency"}, 32'(lat), 32'(elat));
         check({tag, " result"}, r, er);
         check({tag, " exception"}, {31'd0, x}, {31'd0, ee});
      end
   endtask

   initial begin
      logic [31:0] er;
      logic        ee;
      logic [31:0] r;
      int          pulses;
      int          first;
      bit          m;

      vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 32'd3,          32'd4,         32'h0000_000C, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 32'h8000_0000, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'h8000_0000,  32'h8000_0000, 32'h0000_0001, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 32'd0,          32'd5,         32'h0000_0000, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'd100,        32'hFFFF_FF38, 32'h0000_0000, 1'b0};

      reset_n       = 1'b0;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'h0;
      data_operandB = 32'h0;
      #12;
      check("reset result", data_result, 32'h0);
      check("reset exception", {31'd0, data_exception}, 32'd0);
      check("reset rdy", {31'd0, data_resultRDY}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                vecs[i].exp_res, vecs[i].exp_exc);
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         m = 1'($urandom_range(0, 1));
         a = rand_operand();
         b = rand_operand();
         ref_op(m, a, b, er, ee);
         run_op($sformatf("rnd%0d", i), m, !m, a, b, er, ee);
      end

      // ctrl_DIV sampled on E+10 during a multiply must be ignored.
      @(negedge clock);
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd7;
      data_operandB = 32'hFFFF_FFFA;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      pulses    = 0;
      first     = 0;
      r         = 32'h0;
      for (int k = 1; k <= 60; k++) begin
         if (k == 10) begin
            ctrl_DIV      = 1'b1;
            data_operandA = 32'd100;
            data_operandB = 32'd3;
         end
         @(posedge clock);
         #1;
         ctrl_DIV = 1'b0;
         if (data_resultRDY) begin
            pulses++;
            if (pulses == 1) begin
               first = k;
               r     = data_result;
            end
         end
      end
      check("ignore rdy_count", 32'(pulses), 32'd1);
      check("ignore latency", 32'(first), 32'd34);
      check("ignore result", r, 32'hFFFF_FFD6);

      // Reset shortly after E+20 aborts the op immediately and suppresses RDY.
      @(negedge clock);
      ctrl_MULT     = 1'b1;
      data_operandA = 32'h1234_5678;
      data_operandB = 32'd9;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clock);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check("abort result", data_result, 32'h0);
      check("abort exception", {31'd0, data_exception}, 32'd0);
      check("abort rdy", {31'd0, data_resultRDY}, 32'd0);
      check("abort busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      pulses  = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY || busy) pulses++;
      end
      check("abort no_rdy", 32'(pulses), 32'd0);

      run_op("post_reset", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
